alu_share_arbiter: RTL and testbench

//  Shares the single 16-bit ALU between two requesters (port 0, port 1) with valid/ready handshakes.

---
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Shares one combinational 16-bit ALU between two requesters.
//            Arbitrates (round-robin or fixed priority with a starvation
//            guard), registers the winning operands, drives the ALU for one
//            cycle, captures result and flags, and pulses a response to the
//            winning port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    input  logic [2:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [3:0]  req0_shamt,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [2:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [3:0]  req1_shamt,
    output logic        req1_ready,

    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [15:0] resp_data,
    output logic [3:0]  resp_flags,

    output logic [15:0] alu_data1,
    output logic [15:0] alu_data2,
    output logic [2:0]  alu_op,
    output logic [3:0]  alu_shamt,
    input  logic [15:0] alu_out,
    input  logic        alu_sign,
    input  logic        alu_zero,
    input  logic        alu_equal,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
    localparam logic       c_fixed_prio   = (ARB_MODE != 0);

    state_t      r_state;
    logic        r_last_grant;
    logic [3:0]  r_starve;
    logic        r_owner;
    logic        r_resp0_valid;
    logic        r_resp1_valid;
    logic [15:0] r_resp_data;
    logic [3:0]  r_resp_flags;
    logic [15:0] r_alu_data1;
    logic [15:0] r_alu_data2;
    logic [2:0]  r_alu_op;
    logic [3:0]  r_alu_shamt;

    logic        w_tie_pick1;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_idle;
    logic        w_hs0;
    logic        w_hs1;

    // Tie-break choice: round-robin alternates away from the last winner,
    // fixed priority favours port 0 until port 1 has waited long enough.
    assign w_tie_pick1 = c_fixed_prio ? (r_starve == c_starve_limit)
                                      : (r_last_grant == 1'b0);

    // Grant decode: a lone requester always wins; a tie uses the pick above.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant1 = w_tie_pick1;
            w_grant0 = !w_tie_pick1;
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    // Ready is masked by reset so nothing appears accepted while rst_n is low.
    assign w_idle     = rst_n && (r_state == ST_IDLE);
    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign w_hs0      = req0_valid && req0_ready;
    assign w_hs1      = req1_valid && req1_ready;

    // Sequencer: accept in IDLE, drive ALU in ISSUE, pulse response in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_starve      <= 4'd0;
            r_owner       <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_data   <= 16'd0;
            r_resp_flags  <= 4'd0;
            r_alu_data1   <= 16'd0;
            r_alu_data2   <= 16'd0;
            r_alu_op      <= 3'd0;
            r_alu_shamt   <= 4'd0;
        end else begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs0 || w_hs1) begin
                        r_alu_op     <= w_hs1 ? req1_op    : req0_op;
                        r_alu_data1  <= w_hs1 ? req1_a     : req0_a;
                        r_alu_data2  <= w_hs1 ? req1_b     : req0_b;
                        r_alu_shamt  <= w_hs1 ? req1_shamt : req0_shamt;
                        r_owner      <= w_hs1;
                        r_last_grant <= w_hs1;
                        r_state      <= ST_ISSUE;
                        // Count how long port 1 has been passed over.
                        if (w_hs1 || !req1_valid) begin
                            r_starve <= 4'd0;
                        end else if (r_starve != c_starve_limit) begin
                            r_starve <= r_starve + 4'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_resp_data   <= alu_out;
                    r_resp_flags  <= {alu_sign, alu_zero, alu_equal, alu_overflow};
                    r_resp0_valid <= !r_owner;
                    r_resp1_valid <= r_owner;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp_data   = r_resp_data;
    assign resp_flags  = r_resp_flags;
    assign alu_data1   = r_alu_data1;
    assign alu_data2   = r_alu_data2;
    assign alu_op      = r_alu_op;
    assign alu_shamt   = r_alu_shamt;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Scoreboard bench for alu_share_arbiter. Instance 0 uses
//            round-robin, instance 1 fixed priority with STARVE_LIMIT=2.
//            A behavioural ALU sits behind each instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic [15:0] ed;
        logic [3:0]  ef;
    } vec_t;

    typedef struct packed {
        logic        port;
        logic [15:0] d;
        logic [3:0]  f;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [1:0]        v0, v1, rdy0, rdy1, rv0, rv1;
    logic [1:0][2:0]   op0, op1, aop;
    logic [1:0][15:0]  a0, b0, a1, b1, rdata, ad1, ad2, aout;
    logic [1:0][3:0]   s0, s1, rflags, ash;
    logic [1:0]        asg, azr, aeq, aov;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    vec_t vq0[$];
    vec_t vq1[$];
    exp_t sb_rr[$];
    exp_t sb_fp[$];
    logic glog[$];
    int   rcyc[$];

    alu_share_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0[0]), .req0_op(op0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
        .req0_shamt(s0[0]), .req0_ready(rdy0[0]),
        .req1_valid(v1[0]), .req1_op(op1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
        .req1_shamt(s1[0]), .req1_ready(rdy1[0]),
        .resp0_valid(rv0[0]), .resp1_valid(rv1[0]),
        .resp_data(rdata[0]), .resp_flags(rflags[0]),
        .alu_data1(ad1[0]), .alu_data2(ad2[0]), .alu_op(aop[0]), .alu_shamt(ash[0]),
        .alu_out(aout[0]), .alu_sign(asg[0]), .alu_zero(azr[0]),
        .alu_equal(aeq[0]), .alu_overflow(aov[0])
    );

    alu_share_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(2)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0[1]), .req0_op(op0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
        .req0_shamt(s0[1]), .req0_ready(rdy0[1]),
        .req1_valid(v1[1]), .req1_op(op1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
        .req1_shamt(s1[1]), .req1_ready(rdy1[1]),
        .resp0_valid(rv0[1]), .resp1_valid(rv1[1]),
        .resp_data(rdata[1]), .resp_flags(rflags[1]),
        .alu_data1(ad1[1]), .alu_data2(ad2[1]), .alu_op(aop[1]), .alu_shamt(ash[1]),
        .alu_out(aout[1]), .alu_sign(asg[1]), .alu_zero(azr[1]),
        .alu_equal(aeq[1]), .alu_overflow(aov[1])
    );

    // Behavioural ALU: {data[15:0], sign, zero, equal, overflow}
    function automatic logic [19:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] sh);
        logic [15:0] d;
        logic        ov;
        d  = 16'd0;
        ov = 1'b0;
        case (op)
            3'd0: d = b;
            3'd1: begin d = a + b; ov = (a[15] == b[15]) && (d[15] != a[15]); end
            3'd2: begin d = a - b; ov = (a[15] != b[15]) && (d[15] != a[15]); end
            3'd3: d = a >> sh;
            3'd4: d = a << sh;
            3'd5: d = ~(a & b);
            3'd6: d = a;
            default: d = (a > b) ? a : b;
        endcase
        return {d, d[15], (d == 16'd0), (a == b), ov};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_alu
        logic [19:0] w_res;
        assign w_res   = alu_fn(aop[g], ad1[g], ad2[g], ash[g]);
        assign aout[g] = w_res[19:4];
        assign asg[g]  = w_res[3];
        assign azr[g]  = w_res[2];
        assign aeq[g]  = w_res[1];
        assign aov[g]  = w_res[0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] sh, input logic [15:0] ed, input logic [3:0] ef);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh; v.ed = ed; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input int inst, input logic port, input vec_t v);
        exp_t e;
        e.port = port; e.d = v.ed; e.f = v.ef;
        if (inst == 0) sb_rr.push_back(e);
        else           sb_fp.push_back(e);
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    task automatic mon(input int inst);
        exp_t e;
        if (rv0[inst] || rv1[inst]) begin
            if (inst == 0) rcyc.push_back(cyc);
            if (rv0[inst] && rv1[inst]) chk($sformatf("resp_both_inst%0d", inst), 32'd1, 32'd0);
            if ((inst == 0 && sb_rr.size() == 0) || (inst == 1 && sb_fp.size() == 0)) begin
                chk($sformatf("unexpected_resp_inst%0d", inst), 32'd1, 32'd0);
            end else begin
                e = (inst == 0) ? sb_rr.pop_front() : sb_fp.pop_front();
                chk($sformatf("resp_inst%0d", inst),
                    {11'd0, rv1[inst], rdata[inst], rflags[inst]}, {11'd0, e.port, e.d, e.f});
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Present queued vectors on both ports of an instance until all are taken.
    task automatic run_ops(input int inst, input int budget);
        int i0 = 0;
        int i1 = 0;
        int n  = 0;
        while ((i0 < vq0.size() || i1 < vq1.size()) && n < budget) begin
            v0[inst] = (i0 < vq0.size());
            v1[inst] = (i1 < vq1.size());
            if (i0 < vq0.size()) begin
                op0[inst] = vq0[i0].op; a0[inst] = vq0[i0].a; b0[inst] = vq0[i0].b; s0[inst] = vq0[i0].sh;
            end
            if (i1 < vq1.size()) begin
                op1[inst] = vq1[i1].op; a1[inst] = vq1[i1].a; b1[inst] = vq1[i1].b; s1[inst] = vq1[i1].sh;
            end
            @(negedge clk);
            if (rdy0[inst] && rdy1[inst]) chk("both_ready", 32'd1, 32'd0);
            if (v0[inst] && rdy0[inst]) begin
                push_exp(inst, 1'b0, vq0[i0]); glog.push_back(1'b0); i0++;
            end else if (v1[inst] && rdy1[inst]) begin
                push_exp(inst, 1'b1, vq1[i1]); glog.push_back(1'b1); i1++;
            end
            @(posedge clk); #1;
            n++;
        end
        if (i0 < vq0.size() || i1 < vq1.size()) chk("accept_timeout", 32'd1, 32'd0);
        v0[inst] = 1'b0;
        v1[inst] = 1'b0;
        n = 0;
        while (((inst == 0) ? sb_rr.size() : sb_fp.size()) != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", (inst == 0) ? sb_rr.size() : sb_fp.size(), 32'd0);
    endtask

    task automatic chk_order(input string nm, input logic [5:0] req, input int n);
        chk({nm, "_count"}, glog.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < glog.size()) chk($sformatf("%s_grant%0d", nm, k), {31'd0, glog[k]}, {31'd0, req[k]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vadd;
        rst_n = 1'b0;
        v0 = 2'b11; v1 = 2'b11;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; s0 = '0; s1 = '0;
        op0[0] = 3'd1; op0[1] = 3'd1; op1[0] = 3'd2; op1[1] = 3'd2;

        // Reset held three cycles with both requesters asserting valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready0_%0d", i), {31'd0, rdy0[i]}, 32'd0);
            chk($sformatf("rst_ready1_%0d", i), {31'd0, rdy1[i]}, 32'd0);
            chk($sformatf("rst_resp_%0d", i), {30'd0, rv0[i], rv1[i]}, 32'd0);
            chk($sformatf("rst_data_%0d", i), {12'd0, rdata[i], rflags[i]}, 32'd0);
            chk($sformatf("rst_alu_%0d", i), {9'd0, aop[i], ad1[i], ash[i]}, 32'd0);
        end
        @(posedge clk); #1;
        v0 = 2'b00; v1 = 2'b00;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add on port 0 with cycle-exact checks
        vadd = mk(3'd1, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b1001);
        v0[0] = 1'b1; op0[0] = vadd.op; a0[0] = vadd.a; b0[0] = vadd.b; s0[0] = vadd.sh;
        @(negedge clk);
        chk("t2_ready0_c0", {31'd0, rdy0[0]}, 32'd1);
        chk("t2_ready1_c0", {31'd0, rdy1[0]}, 32'd0);
        if (rdy0[0]) push_exp(0, 1'b0, vadd);
        @(posedge clk); #1;
        v0[0] = 1'b0;
        @(negedge clk);
        chk("t2_aluop_c1", {29'd0, aop[0]}, 32'd1);
        chk("t2_aluab_c1", {ad1[0], ad2[0]}, {16'h7FFF, 16'h0001});
        chk("t2_resp_c1", {30'd0, rv0[0], rv1[0]}, 32'd0);
        @(negedge clk);
        chk("t2_resp_c2", {30'd0, rv0[0], rv1[0]}, 32'd2);
        @(negedge clk);
        chk("t2_resp_c3", {30'd0, rv0[0], rv1[0]}, 32'd0);
        chk("t2_alu_hold", {29'd0, aop[0]}, 32'd1);
        @(posedge clk); #1;

        // Compare-equal on port 1
        vq0.delete(); vq1.delete(); glog.delete();
        vq1.push_back(mk(3'd6, 16'h1234, 16'h1234, 4'd0, 16'h1234, 4'b0010));
        run_ops(0, 10);
        chk_order("t5", 6'b000001, 1);

        // Round-robin tie: both ports valid continuously
        vq0.delete(); vq1.delete(); glog.delete(); rcyc.delete();
        vq0.push_back(mk(3'd2, 16'h0005, 16'h0007, 4'd0, 16'hFFFE, 4'b1000));
        vq0.push_back(mk(3'd4, 16'h0003, 16'h0000, 4'd4, 16'h0030, 4'b0000));
        vq1.push_back(mk(3'd5, 16'hFFFF, 16'hFFFF, 4'd0, 16'h0000, 4'b0110));
        vq1.push_back(mk(3'd7, 16'h0003, 16'h0009, 4'd0, 16'h0009, 4'b0000));
        run_ops(0, 30);
        chk_order("t3", 6'b001010, 4);
        chk("t3_resp_count", rcyc.size(), 32'd4);
        for (int k = 0; k + 1 < rcyc.size(); k++)
            chk($sformatf("t3_gap%0d", k), rcyc[k+1] - rcyc[k], 32'd3);

        // Fixed priority with starvation guard (limit 2)
        vq0.delete(); vq1.delete(); glog.delete();
        vq0.push_back(mk(3'd1, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b1001));
        vq0.push_back(mk(3'd2, 16'h0005, 16'h0007, 4'd0, 16'hFFFE, 4'b1000));
        vq0.push_back(mk(3'd4, 16'h0003, 16'h0000, 4'd4, 16'h0030, 4'b0000));
        vq0.push_back(mk(3'd7, 16'h0003, 16'h0009, 4'd0, 16'h0009, 4'b0000));
        vq1.push_back(mk(3'd5, 16'hFFFF, 16'hFFFF, 4'd0, 16'h0000, 4'b0110));
        vq1.push_back(mk(3'd3, 16'h8000, 16'h0000, 4'd15, 16'h0001, 4'b0000));
        run_ops(1, 40);
        chk_order("t4", 6'b100100, 6);

        // Reset during ISSUE: aborted op must never respond
        v1[0] = 1'b1; op1[0] = 3'd0; a1[0] = 16'h0001; b1[0] = 16'h0000; s1[0] = 4'd0;
        @(negedge clk);
        chk("t6_ready1", {31'd0, rdy1[0]}, 32'd1);
        @(posedge clk); #1;
        v1[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vq0.delete(); vq1.delete(); glog.delete();
        vq0.push_back(mk(3'd1, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b1001));
        vq1.push_back(mk(3'd0, 16'h0001, 16'h0000, 4'd0, 16'h0000, 4'b0100));
        run_ops(0, 20);
        chk_order("t6", 6'b000010, 2);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
